// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared fetch constants and state encoding (package mips_pkg)
package mips_pkg;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;
    typedef enum logic {FETCH, HOLD} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: request/ready handshake between fetch stage and instruction memory
interface instruction_fetch_if;
    logic imemReq;
    logic [31:0] imemAddr;
    logic imemReady;
    logic [31:0] imemData;
    modport master(output imemReq, imemAddr, input imemReady, imemData);
    modport slave(input imemReq, imemAddr, output imemReady, imemData);
endinterface

// File: rtl/instruction_fetch_pc_register.sv
// pc_register: word-aligned program counter with reset, redirect load and increment
module pc_register
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] loadValue,
    input  logic        inc,
    output logic [31:0] pc
);
    always_ff @(posedge clk)
        if (reset) pc <= RESET_PC & 32'hFFFF_FFFC;
        else if (load) pc <= loadValue & 32'hFFFF_FFFC;
        else if (inc) pc <= pc + PC_INC;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, memory request FSM and registered instruction output.
// Optional IF_PERF_CNT_EN adds the fetchCount accepted-fetch counter.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branchTaken,
    input  logic [31:0]           branchTarget,
    instruction_fetch_if.master   imem,
    output logic [31:0]           instructionOut,
    output logic [31:0]           pcOut,
    output logic [31:0]           pcPlus4Out,
    output logic                  instrValid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]           fetchCount
`endif
);
    logic [31:0] pc;
    logic accept;
    fetch_state_t state;
    // a redirect discards whatever the memory returns in the same cycle
    assign accept = state == FETCH && imem.imemReady && !branchTaken;
    assign imem.imemReq = !reset && state == FETCH;
    assign imem.imemAddr = pc;
    pc_register #(.RESET_PC(RESET_PC)) u_pc (
        .clk(clk),
        .reset(reset),
        .load(branchTaken),
        .loadValue(branchTarget),
        .inc(accept),
        .pc(pc)
    );
    always_ff @(posedge clk)
        if (reset) begin
            state <= FETCH;
            instrValid <= 1'b0;
            instructionOut <= NOP_WORD;
            pcOut <= '0;
            pcPlus4Out <= '0;
        end else if (accept) begin
            instructionOut <= imem.imemData;
            pcOut <= pc;
            pcPlus4Out <= pc + PC_INC;
            instrValid <= 1'b1;
            state <= stall ? HOLD : FETCH;
        end else if (branchTaken || !stall) begin
            instrValid <= 1'b0;
            instructionOut <= NOP_WORD;
            state <= FETCH;
        end
`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk)
        if (reset) fetchCount <= '0;
        else if (accept) fetchCount <= fetchCount + 32'd1;
`endif
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction field splitter: holds the PC, requests words from instruction memory over a ready/valid-style handshake, and registers the fetched word.
- Presents the registered word to the splitter together with its PC and PC+4.
- Supports downstream stall and branch/jump redirect with flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, value driven on instructionOut when no valid instruction is held (MIPS sll $0,$0,0).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  downstream cannot accept; hold the current output.
- branchTaken  in  1  one-cycle redirect pulse from the branch/jump logic.
- branchTarget  in  32  redirect address; bits [1:0] are ignored.
- imemReq  out  1  fetch request to instruction memory.
- imemAddr  out  32  word-aligned fetch address; combinational from the PC.
- imemReady  in  1  memory returns imemData this cycle for the current imemAddr.
- imemData  in  32  fetched instruction word.
- instructionOut  out  32  registered instruction to the splitter.
- pcOut  out  32  PC of instructionOut.
- pcPlus4Out  out  32  pcOut + 4.
- instrValid  out  1  instructionOut holds a real instruction.

Behaviour:
- Reset (synchronous, highest priority):
  - pc = RESET_PC, state = FETCH.
  - instrValid = 0, instructionOut = NOP_WORD, pcOut = 0, pcPlus4Out = 0.
  - imemReq = 0 during any cycle where reset = 1.
- pc[1:0] is always 00. pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- States:
  - FETCH:
    - imemReq = 1, imemAddr = pc.
    - On imemReady: instructionOut <= imemData, pcOut <= pc, pcPlus4Out <= pc + 4, instrValid <= 1, pc <= pc + 4.
    - Next state = HOLD if stall, else FETCH.
    - No imemReady and stall = 0: instrValid <= 0, instructionOut <= NOP_WORD (bubble; the previous word was consumed).
    - No imemReady and stall = 1: outputs hold.
  - HOLD:
    - imemReq = 0; all outputs and pc hold.
    - When stall = 0, the held word is consumed that cycle: instrValid <= 0, instructionOut <= NOP_WORD, next state = FETCH.
- Latency: one cycle from the imemReady edge to instrValid. Zero-wait memory sustains one instruction per cycle.
- Memory contract:
  - Memory samples imemAddr only in the cycle it asserts imemReady.
  - imemAddr may change while imemReq is held without ready, e.g. on redirect.
- Redirect (branchTaken = 1), priority below reset and above stall and imemReady, in any state:
  - pc <= {branchTarget[31:2], 2'b00}.
  - instrValid <= 0, instructionOut <= NOP_WORD (flush).
  - State <= FETCH.
  - imemData returned in the same cycle is discarded.
  - The first request to the target address is issued in the next cycle.
- Simultaneous redirect and stall: the redirect wins; the flushed bubble is not held.
- Reset mid-request: the outstanding request is abandoned, with no output update.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds output port fetchCount [31:0].
  - Increments by 1 on each imemReady accepted in FETCH without a redirect that cycle; wraps at 2^32.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package (mips_pkg): NOP_WORD, RESET_PC default, fetch state enum (FETCH, HOLD), PC_INC = 4.
- One natural sub-module, pc_register: holds pc and handles reset/redirect/increment muxing, with inputs load, loadValue, inc. The FSM and output register stay in instruction_fetch.

Test Plan:
- Reset, zero-wait memory (imemReady = 1) -> imemAddr 0x0, 0x4, 0x8 on consecutive cycles; instrValid = 1 from cycle 2; pcPlus4Out = pcOut + 4.
- imemReady low for 3 cycles at 0x8 -> imemAddr stays 0x8; instrValid = 0 with NOP_WORD output; the word is captured on the ready cycle.
- stall = 1 for 2 cycles while 0x4 is valid -> outputs frozen at pcOut = 0x4; imemReq = 0 in HOLD; fetch resumes at 0x8 after release.
- branchTaken with branchTarget = 0x0000_0103 while imemReady = 1 -> returned word dropped; instrValid = 0 next cycle; next imemAddr = 0x0000_0100.
- branchTaken and stall in the same cycle -> flush wins; state FETCH; imemAddr = target.
- RESET_PC = 32'hFFFF_FFFC -> the second fetch address is 0x0000_0000. With IF_PERF_CNT_EN, fetchCount = 2 after two accepted fetches and unchanged on a flushed fetch.
